// File: rtl/reflet_bus_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | reflet_bus_pkg: shared state and owner encodings for the bus arbiter.     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package reflet_bus_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_M0   = 2'd1,
        OWNER_M1   = 2'd2
    } owner_t;

    function automatic owner_t owner_of(input logic [1:0] state);
        owner_t owner;
        case (state)
            ST_OWN0: owner = OWNER_M0;
            ST_OWN1: owner = OWNER_M1;
            default: owner = OWNER_NONE;
        endcase
        return owner;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reflet_bus_arbiter_fsm.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | reflet_bus_arbiter_fsm: ownership state, round-robin pointer, burst count.|
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module reflet_bus_arbiter_fsm
    import reflet_bus_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req,
    input  logic       m1_req,
    output logic [1:0] state,
    output logic       m0_grant,
    output logic       m1_grant
);

    localparam logic [7:0] C_BURST_MAX  = 8'(MAX_BURST);
    localparam logic [7:0] C_BURST_LAST = 8'(MAX_BURST - 1);

    logic [1:0] r_state;
    logic       r_prio;        // 0: m0 wins the next tie, 1: m1 wins
    logic [7:0] r_burst;

    logic [1:0] w_next_state;
    logic       w_next_prio;
    logic [7:0] w_next_burst;
    logic       w_own_req;
    logic       w_oth_req;
    logic [1:0] w_oth_state;

    always_comb begin
        w_own_req   = (r_state == ST_OWN1) ? m1_req : m0_req;
        w_oth_req   = (r_state == ST_OWN1) ? m0_req : m1_req;
        w_oth_state = (r_state == ST_OWN1) ? ST_OWN0 : ST_OWN1;
    end

    always_comb begin
        w_next_state = r_state;
        w_next_prio  = r_prio;
        w_next_burst = r_burst;
        case (r_state)
            ST_OWN0, ST_OWN1: begin
                if (!w_own_req) begin
                    w_next_state = w_oth_req ? w_oth_state : ST_IDLE;
                end else if (!w_oth_req) begin
                    w_next_burst = (r_burst >= C_BURST_MAX) ? C_BURST_MAX : r_burst + 8'd1;
                end else if (r_burst < C_BURST_LAST) begin
                    w_next_burst = r_burst + 8'd1;
                end else begin
                    // Forced hand-over: the master losing the bus wins the next tie.
                    w_next_state = w_oth_state;
                    w_next_prio  = (r_state == ST_OWN1);
                end
            end
            default: begin
                if (m0_req && m1_req) begin
                    w_next_state = r_prio ? ST_OWN1 : ST_OWN0;
                    w_next_prio  = ~r_prio;
                end else if (m0_req) begin
                    w_next_state = ST_OWN0;
                end else if (m1_req) begin
                    w_next_state = ST_OWN1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
        endcase
        if (w_next_state != r_state) begin
            w_next_burst = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
            r_burst <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_prio  <= w_next_prio;
            r_burst <= w_next_burst;
        end
    end

    assign state    = r_state;
    assign m0_grant = (r_state == ST_OWN0);
    assign m1_grant = (r_state == ST_OWN1);

endmodule
`default_nettype wire

// File: rtl/reflet_bus_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | reflet_bus_arbiter: two-master single-port bus arbiter with read steering.|
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module reflet_bus_arbiter
    import reflet_bus_pkg::*;
#(
    parameter int WORDSIZE  = 16,
    parameter int MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic [WORDSIZE-1:0] m0_addr,
    input  logic [WORDSIZE-1:0] m0_data_out,
    input  logic                m0_write_en,
    output logic [WORDSIZE-1:0] m0_data_in,
    output logic                m0_grant,
    input  logic                m1_req,
    input  logic [WORDSIZE-1:0] m1_addr,
    input  logic [WORDSIZE-1:0] m1_data_out,
    input  logic                m1_write_en,
    output logic [WORDSIZE-1:0] m1_data_in,
    output logic                m1_grant,
    output logic [WORDSIZE-1:0] s_addr,
    output logic [WORDSIZE-1:0] s_data_out,
    output logic                s_write_en,
    input  logic [WORDSIZE-1:0] s_data_in
);

    logic [1:0] w_state;
    owner_t     r_last_owner;

    reflet_bus_arbiter_fsm #(
        .MAX_BURST (MAX_BURST)
    ) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m1_req   (m1_req),
        .state    (w_state),
        .m0_grant (m0_grant),
        .m1_grant (m1_grant)
    );

    // The write strobe is qualified by req so a master releasing the bus cannot write.
    always_comb begin
        s_addr     = '0;
        s_data_out = '0;
        s_write_en = 1'b0;
        case (w_state)
            ST_OWN0: begin
                s_addr     = m0_addr;
                s_data_out = m0_data_out;
                s_write_en = m0_write_en & m0_req;
            end
            ST_OWN1: begin
                s_addr     = m1_addr;
                s_data_out = m1_data_out;
                s_write_en = m1_write_en & m1_req;
            end
            default: ;
        endcase
    end

    // Slave read data lags the address by a cycle, so steer it by last cycle's owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_owner <= OWNER_NONE;
        end else begin
            r_last_owner <= owner_of(w_state);
        end
    end

    assign m0_data_in = (r_last_owner == OWNER_M0) ? s_data_in : '0;
    assign m1_data_in = (r_last_owner == OWNER_M1) ? s_data_in : '0;

endmodule
`default_nettype wire
